// File: rtl/axilite_read_channel.sv
// ---------------------------------------------------------------------------
// axilite_read_channel
//
// AXI4-Lite read-side responder for the coprocessor CSR bank. One read is
// in flight at a time: the AR beat is accepted, the byte address is decoded
// into a word index of the flat register vector, and the selected word is
// returned on R together with a response code. It reads the same regs vector
// as the companion write channel.
//
// Every AXI output comes straight from a flop, so there is no combinational
// path from any AXI input to any AXI output.
//
// Optional feature (compile-time macro AXILITE_RD_STATUS_EN):
//   adds the read-only status port and the STATUS_SIZE parameter. Status
//   words are mapped directly above the CSR words. Without the macro every
//   index at or above NUM_REGS decodes to DECERR.
//
// Parameters
//   DATA_SIZE    width of regs; NUM_REGS = DATA_SIZE / DATA_WIDTH
//   ADDR_SIZE    araddr / rd_index width
//   DATA_WIDTH   rdata width (at least 16 so the byte-offset field is non-empty)
//   STATUS_SIZE  status width (macro builds only)
//
// Response codes: OKAY = 0, SLVERR = 2, DECERR = 3 (EXOKAY = 1 is never
// produced by this responder).
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   araddr    in   read byte address
//   arvalid   in   address valid
//   arready   out  address ready (registered)
//   rdata     out  read data (registered, held until accepted)
//   rresp     out  read response (registered, held until accepted)
//   rvalid    out  read data valid (registered)
//   rready    in   master accepts read data
//   regs      in   CSR contents, word k = regs[k*DATA_WIDTH +: DATA_WIDTH]
//   status    in   read-only status words (macro builds only)
//   rd_pulse  out  one-cycle pulse the cycle after every accepted read
//   rd_index  out  word index of the most recently accepted read
// ---------------------------------------------------------------------------
module axilite_read_channel #(
  parameter int DATA_SIZE   = 128,
  parameter int ADDR_SIZE   = 32,
`ifdef AXILITE_RD_STATUS_EN
  parameter int STATUS_SIZE = 64,
`endif
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic [DATA_SIZE-1:0]   regs,
`ifdef AXILITE_RD_STATUS_EN
  input  logic [STATUS_SIZE-1:0] status,
`endif
  output logic                   rd_pulse,
  output logic [ADDR_SIZE-1:0]   rd_index
);

  localparam int NUM_REGS   = DATA_SIZE / DATA_WIDTH;
  localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
`ifdef AXILITE_RD_STATUS_EN
  localparam int NUM_STATUS = STATUS_SIZE / DATA_WIDTH;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE_WAIT = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RESP      = 2'd2
  } state_e;

  state_e                  state_r;
  state_e                  state_nxt_s;

  logic                    arready_r;
  logic                    arready_nxt_s;
  logic                    rvalid_r;
  logic                    rvalid_nxt_s;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic [DATA_WIDTH-1:0]   rdata_nxt_s;
  logic [1:0]              rresp_r;
  logic [1:0]              rresp_nxt_s;
  logic                    rd_pulse_r;
  logic                    rd_pulse_nxt_s;
  logic [ADDR_SIZE-1:0]    rd_index_r;
  logic [ADDR_SIZE-1:0]    rd_index_nxt_s;

  logic [ADDR_SIZE-1:0]    dec_idx_s;
  logic [DATA_WIDTH-1:0]   dec_data_s;
  logic [1:0]              dec_resp_s;

  // Decode the presented address into word index, read data and response.
  // The index is compared at full address width so that high address bits
  // can never alias onto a valid word.
  always_comb begin
    dec_idx_s  = araddr >> WORD_SHIFT;
    dec_data_s = {DATA_WIDTH{1'b0}};
    dec_resp_s = RESP_DECERR;
    if (araddr[WORD_SHIFT-1:0] != {WORD_SHIFT{1'b0}}) begin
      dec_resp_s = RESP_SLVERR;
    end else if (dec_idx_s < ADDR_SIZE'(NUM_REGS)) begin
      dec_resp_s = RESP_OKAY;
      // One-hot AND-OR mux keeps the word select free of priority logic.
      for (int k = 0; k < NUM_REGS; k++) begin
        dec_data_s = dec_data_s |
                     ({DATA_WIDTH{dec_idx_s == ADDR_SIZE'(k)}} &
                      regs[k*DATA_WIDTH +: DATA_WIDTH]);
      end
`ifdef AXILITE_RD_STATUS_EN
    end else if (dec_idx_s < ADDR_SIZE'(NUM_REGS + NUM_STATUS)) begin
      dec_resp_s = RESP_OKAY;
      for (int k = 0; k < NUM_STATUS; k++) begin
        dec_data_s = dec_data_s |
                     ({DATA_WIDTH{dec_idx_s == ADDR_SIZE'(NUM_REGS + k)}} &
                      status[k*DATA_WIDTH +: DATA_WIDTH]);
      end
`endif
    end else begin
      dec_resp_s = RESP_DECERR;
    end
  end

  // Next-state and next-output logic of the read FSM.
  always_comb begin
    state_nxt_s    = state_r;
    arready_nxt_s  = arready_r;
    rvalid_nxt_s   = rvalid_r;
    rdata_nxt_s    = rdata_r;
    rresp_nxt_s    = rresp_r;
    rd_pulse_nxt_s = 1'b0;
    rd_index_nxt_s = rd_index_r;
    case (state_r)
      ST_IDLE_WAIT: begin
        // One settling cycle after reset before AR is offered.
        state_nxt_s   = ST_IDLE;
        arready_nxt_s = 1'b1;
      end
      ST_IDLE: begin
        if (arvalid && arready_r) begin
          // regs is sampled here; later changes do not affect this beat.
          state_nxt_s    = ST_RESP;
          arready_nxt_s  = 1'b0;
          rvalid_nxt_s   = 1'b1;
          rdata_nxt_s    = dec_data_s;
          rresp_nxt_s    = dec_resp_s;
          rd_pulse_nxt_s = 1'b1;
          rd_index_nxt_s = dec_idx_s;
        end else begin
          arready_nxt_s = 1'b1;
        end
      end
      ST_RESP: begin
        if (rvalid_r && rready) begin
          state_nxt_s   = ST_IDLE;
          rvalid_nxt_s  = 1'b0;
          arready_nxt_s = 1'b1;
        end else begin
          rvalid_nxt_s  = 1'b1;
          arready_nxt_s = 1'b0;
        end
      end
      default: begin
        // Unreachable encoding: recover through the post-reset path.
        state_nxt_s   = ST_IDLE_WAIT;
        arready_nxt_s = 1'b0;
        rvalid_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset discards any pending read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE_WAIT;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= {DATA_WIDTH{1'b0}};
      rresp_r    <= RESP_OKAY;
      rd_pulse_r <= 1'b0;
      rd_index_r <= {ADDR_SIZE{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      arready_r  <= arready_nxt_s;
      rvalid_r   <= rvalid_nxt_s;
      rdata_r    <= rdata_nxt_s;
      rresp_r    <= rresp_nxt_s;
      rd_pulse_r <= rd_pulse_nxt_s;
      rd_index_r <= rd_index_nxt_s;
    end
  end

  assign arready  = arready_r;
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign rresp    = rresp_r;
  assign rd_pulse = rd_pulse_r;
  assign rd_index = rd_index_r;

endmodule

// File: tb/tb_axilite_read_channel.sv
// ---------------------------------------------------------------------------
// tb_axilite_read_channel
//
// Scoreboard bench for axilite_read_channel. The stimulus process issues AR
// beats and, at each accepted handshake, pushes the reference model's
// expected response into a queue. A separate monitor samples the DUT 1 ns
// after every rising edge, pops on each new R beat and checks data, response,
// index, pulse, latency, stability under backpressure and arready.
// Inputs change 2-3 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axilite_read_channel;

  localparam int NREGS = 4;
`ifdef AXILITE_RD_STATUS_EN
  localparam int NSTAT = 2;
`else
  localparam int NSTAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] regs;
`ifdef AXILITE_RD_STATUS_EN
  logic [63:0]  status;
`endif
  logic         rd_pulse;
  logic [31:0]  rd_index;

  axilite_read_channel dut (
    .clk      (clk),
    .rst      (rst),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .regs     (regs),
`ifdef AXILITE_RD_STATUS_EN
    .status   (status),
`endif
    .rd_pulse (rd_pulse),
    .rd_index (rd_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  int   acc_seen = 0;
  bit   mon_en      = 1'b0;
  bit   beat_active = 1'b0;
  bit   acc_now;
  bit   rready_rand = 1'b0;
  bit   regs_rand   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: word-aligned byte address -> word index; misaligned is
  // SLVERR, CSR words then status words are OKAY, anything else DECERR.
  function automatic exp_t model(input logic [31:0] addr, input logic [127:0] r);
    exp_t            e;
    longint unsigned idx;
    logic [127:0]    sh;
`ifdef AXILITE_RD_STATUS_EN
    logic [63:0]     shs;
`endif
    idx    = {32'd0, addr} / 64'd4;
    e.idx  = addr / 32'd4;
    e.data = 32'd0;
    if (addr % 32'd4 != 32'd0) begin
      e.resp = 2'd2;
    end else if (idx < NREGS) begin
      sh     = r >> (idx * 32);
      e.data = sh[31:0];
      e.resp = 2'd0;
`ifdef AXILITE_RD_STATUS_EN
    end else if (idx < NREGS + NSTAT) begin
      shs    = status >> ((idx - NREGS) * 32);
      e.data = shs[31:0];
      e.resp = 2'd0;
`endif
    end else begin
      e.resp = 2'd3;
    end
    return e;
  endfunction

  // Monitor: compares every presented R beat against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (beat_active && rready) beat_active = 1'b0;  // R handshake at this edge
      acc_now  = (acc_cnt != acc_seen);
      acc_seen = acc_cnt;
      if (acc_now) begin
        check("rvalid_after_accept", rvalid, 1'b1);
        if (exp_q.size() == 0) begin
          fail_now("scoreboard_empty");
        end else begin
          cur = exp_q.pop_front();
          beat_active = 1'b1;
          check("rd_index", rd_index, cur.idx);
        end
      end else begin
        check("rvalid", rvalid, beat_active);
      end
      if (beat_active && rvalid) begin
        check("rdata", rdata, cur.data);
        check("rresp", rresp, cur.resp);
      end
      check("rd_pulse", rd_pulse, acc_now);
      check("arready", arready, !beat_active);
    end
  end

  // Background rready and regs activity.
  always @(posedge clk) begin
    #3;
    if (rready_rand) rready = ($urandom_range(0, 3) != 0);
    if (regs_rand) regs = {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  task automatic do_read(input logic [31:0] addr);
    int waited = 0;
    @(posedge clk);
    #2;
    arvalid = 1'b1;
    araddr  = addr;
    while (arready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (arready !== 1'b1) begin
      fail_now("ar_handshake");
      arvalid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(model(addr, regs));
      acc_cnt++;
      #2;
      arvalid = 1'b0;
      araddr  = $urandom();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((beat_active || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (beat_active || exp_q.size() != 0) fail_now("wait_idle");
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          sel;
    // Reset held with arvalid high: nothing may be offered or returned.
    rst = 1'b0; arvalid = 1'b1; araddr = 32'd0; rready = 1'b0; regs = '0;
`ifdef AXILITE_RD_STATUS_EN
    status = 64'd0;
`endif
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_arready", arready, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rresp", rresp, 2'd0);
      check("rst_rd_pulse", rd_pulse, 1'b0);
      check("rst_rd_index", rd_index, 32'd0);
    end
    #1;
    arvalid = 1'b0;
    rst = 1'b1;
    check("release_arready", arready, 1'b0);
    @(posedge clk);
    #1;
    check("first_edge_arready", arready, 1'b1);
    check("first_edge_rvalid", rvalid, 1'b0);
    mon_en = 1'b1;

    // Basic read of word 2.
    rready = 1'b1;
    regs = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    do_read(32'h8);
    wait_idle();

    // Backpressure with regs changing under the pending beat.
    rready = 1'b0;
    regs_rand = 1'b1;
    do_read(32'h4);
    repeat (5) @(posedge clk);
    #3;
    rready = 1'b1;
    wait_idle();
    regs_rand = 1'b0;

    // Error responses, including high address bits that must not alias.
    do_read(32'h6);
    do_read(32'h10);
    do_read(32'hF000_0000);
    do_read(32'h4000_0004);
    do_read(32'h3);
    do_read(32'hC);
    wait_idle();

`ifdef AXILITE_RD_STATUS_EN
    status = {32'hCAFEF00D, 32'h12345678};
    do_read(32'h10);
    do_read(32'h14);
    do_read(32'h18);
    wait_idle();
`endif

    // Randomized traffic with random backpressure and register churn.
    rready_rand = 1'b1;
    regs_rand   = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: a = $urandom_range(0, NREGS + NSTAT + 1) * 4;
        1: a = $urandom_range(0, NREGS + NSTAT + 1) * 4 + $urandom_range(1, 3);
        2: a = $urandom();
        default: a = $urandom_range(0, NREGS - 1) * 4;
      endcase
`ifdef AXILITE_RD_STATUS_EN
      status = {$urandom(), $urandom()};
`endif
      do_read(a);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rready_rand = 1'b0;
    #3;
    rready = 1'b1;
    wait_idle();
    regs_rand = 1'b0;

    // Reset while a beat is pending: rvalid must fall without a clock edge.
    rready = 1'b0;
    do_read(32'h8);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst_rvalid", rvalid, 1'b0);
    check("async_rst_arready", arready, 1'b0);
    check("async_rst_rd_pulse", rd_pulse, 1'b0);
    exp_q.delete();
    beat_active = 1'b0;
    acc_seen = acc_cnt;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rerelease_arready", arready, 1'b1);
    check("rerelease_rvalid", rvalid, 1'b0);
    mon_en = 1'b1;
    rready = 1'b1;
    regs = {32'h0, 32'h0, 32'h0, 32'hA5A5_0001};
    do_read(32'h0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
